// File: rtl/systolic_skew_feeder_pkg.sv
// systolic_skew_feeder_pkg: shared state encoding and default dimensions for the skew feeder
package systolic_skew_feeder_pkg;
  localparam int DEF_N = 16;
  localparam int DEF_W = 8;
  localparam int LANE_W = DEF_W;
  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;
endpackage

// File: rtl/systolic_skew_feeder_delay.sv
// skew_delay_line: registered delay line of DEPTH stages that clears to zero on reset
module skew_delay_line
  import systolic_skew_feeder_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int W = LANE_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] sr_q [DEPTH];
  logic [W-1:0] sr_d [DEPTH];
  // shift the new element in at stage 0 and move every stage one step along
  always_comb begin
    sr_d[0] = din;
    for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
  end
  // stage registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    else sr_q <= sr_d;
  end
  assign dout = sr_q[DEPTH-1];
endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: accepts N operand beats, skews lane j by j cycles, flushes and pulses en_in
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [W*N-1:0] a_col,
  input  logic [W*N-1:0] b_row,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W*N-1:0] in_a,
  output logic [W*N-1:0] in_b,
  output logic           en_in,
  output logic           busy
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] NL = CW'(N);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, fcnt_q, fcnt_d;
  logic ready_q, ready_d, en_q, en_d;
  logic accept;
  logic [W*N-1:0] push_a, push_b;
  assign accept = in_valid && ready_q;
  assign push_a = accept ? a_col : '0;
  assign push_b = accept ? b_row : '0;
  // next state, beat/flush counters and registered handshake/pulse outputs
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    fcnt_d = fcnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = (N == 1) ? FLUSH : FEED;
        cnt_d = (N == 1) ? '0 : CW'(1);
        fcnt_d = '0;
      end
      FEED: if (accept) begin
        state_d = (cnt_q + CW'(1) == NL) ? FLUSH : FEED;
        cnt_d = (cnt_q + CW'(1) == NL) ? '0 : cnt_q + CW'(1);
      end
      FLUSH: begin
        state_d = (fcnt_q == NL - CW'(1)) ? DONE : FLUSH;
        fcnt_d = (fcnt_q == NL - CW'(1)) ? '0 : fcnt_q + CW'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) || (state_d == FEED);
    en_d = (state_d == DONE);
  end
  // FSM, counter and output registers; ready stays low until the first edge after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      fcnt_q <= '0;
      ready_q <= 1'b0;
      en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fcnt_q <= fcnt_d;
      ready_q <= ready_d;
      en_q <= en_d;
    end
  end
  assign in_ready = ready_q;
  assign en_in = en_q;
  assign busy = (state_q != IDLE);
  for (genvar j = 0; j < N; j++) begin : g_lane
    skew_delay_line #(.DEPTH(j + 1), .W(W)) u_a (
      .clk(clk), .reset_n(reset_n), .din(push_a[W*j +: W]), .dout(in_a[W*j +: W])
    );
    skew_delay_line #(.DEPTH(j + 1), .W(W)) u_b (
      .clk(clk), .reset_n(reset_n), .din(push_b[W*j +: W]), .dout(in_b[W*j +: W])
    );
  end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: directed jobs on N=4 and N=16 feeders with a lane-history reference
module tb_systolic_skew_feeder;
  logic clk = 1'b0;
  logic rstn4, rstn16;
  logic [31:0] a4, b4, ia4, ib4;
  logic [127:0] a16, b16, ia16, ib16;
  logic v4, v16, r4, r16, en4, en16, busy4, busy16;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  systolic_skew_feeder #(.N(4), .W(8)) u_dut4 (
    .clk(clk), .reset_n(rstn4), .a_col(a4), .b_row(b4), .in_valid(v4), .in_ready(r4),
    .in_a(ia4), .in_b(ib4), .en_in(en4), .busy(busy4)
  );
  systolic_skew_feeder #(.N(16), .W(8)) u_dut16 (
    .clk(clk), .reset_n(rstn16), .a_col(a16), .b_row(b16), .in_valid(v16), .in_ready(r16),
    .in_a(ia16), .in_b(ib16), .en_in(en16), .busy(busy16)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_outs(input int n, input logic [127:0] ea, input logic [127:0] eb,
                          input logic en_e, input logic rdy_e, input logic busy_e);
    chk("in_a", (n == 4) ? {96'b0, ia4} : ia16, ea);
    chk("in_b", (n == 4) ? {96'b0, ib4} : ib16, eb);
    chk("en_in", (n == 4) ? en4 : en16, en_e);
    chk("in_ready", (n == 4) ? r4 : r16, rdy_e);
    chk("busy", (n == 4) ? busy4 : busy16, busy_e);
  endtask
  task automatic run_job(input int n, input logic [63:0] vpat, input int en_cyc, input int abort_t);
    logic [127:0] pa[$];
    logic [127:0] pb[$];
    logic [127:0] ea, eb, da, db;
    int k;
    bit acc;
    k = 0;
    for (int t = 0; t < en_cyc + 3; t++) begin
      ea = '0;
      eb = '0;
      for (int j = 0; j < n; j++) if (t - 1 - j >= 0) begin
        ea[8*j +: 8] = pa[t-1-j][8*j +: 8];
        eb[8*j +: 8] = pb[t-1-j][8*j +: 8];
      end
      chk_outs(n, ea, eb, t == en_cyc, (k < n) || (t > en_cyc), (t >= 1) && (t <= en_cyc));
      if (t == abort_t) begin
        if (n == 4) begin rstn4 = 1'b0; v4 = 1'b0; end
        else begin rstn16 = 1'b0; v16 = 1'b0; end
        #1;
        chk_outs(n, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
          tick;
          chk_outs(n, '0, '0, 1'b0, 1'b0, 1'b0);
        end
        if (n == 4) rstn4 = 1'b1;
        else rstn16 = 1'b1;
        tick;
        return;
      end
      da = {$urandom, $urandom, $urandom, $urandom};
      db = {$urandom, $urandom, $urandom, $urandom};
      acc = vpat[t] && (k < n);
      if (acc) for (int j = 0; j < n; j++) begin
        da[8*j +: 8] = (n == 4) ? 8'(k + 1) : 8'($urandom_range(0, 9));
        db[8*j +: 8] = (n == 4) ? 8'd1 : 8'($urandom_range(0, 9));
      end
      if (n == 4) begin v4 = vpat[t]; a4 = da[31:0]; b4 = db[31:0]; end
      else begin v16 = vpat[t]; a16 = da; b16 = db; end
      pa.push_back(acc ? da : '0);
      pb.push_back(acc ? db : '0);
      if (acc) k++;
      tick;
    end
    v4 = 1'b0;
    v16 = 1'b0;
  endtask
  initial begin
    rstn4 = 1'b0;
    rstn16 = 1'b0;
    v4 = 1'b0;
    v16 = 1'b0;
    a4 = $urandom;
    b4 = $urandom;
    a16 = {$urandom, $urandom, $urandom, $urandom};
    b16 = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) tick;
    chk_outs(4, '0, '0, 1'b0, 1'b0, 1'b0);
    chk_outs(16, '0, '0, 1'b0, 1'b0, 1'b0);
    rstn4 = 1'b1;
    rstn16 = 1'b1;
    #1;
    chk("ready4_pre_edge", r4, 1'b0);
    chk("ready16_pre_edge", r16, 1'b0);
    tick;
    chk("ready4_post_edge", r4, 1'b1);
    chk("ready16_post_edge", r16, 1'b1);
    run_job(4, 64'h1EF, 8, -1);
    run_job(4, 64'h33, 10, -1);
    run_job(16, 64'hFFFF, 32, 21);
    run_job(16, 64'hFFFF, 32, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream stage of the `top` systolic array. Accepts one N-lane operand beat per handshake (column k of A and row k of B, 8-bit elements), skews lane j by j cycles, and drives the array's `in_a`/`in_b`/`en_in` inputs directly. After N beats it flushes zeros until the last lane drains, then pulses `en_in` for one cycle. This replaces the hand-skewed stimulus currently written in benches.

## Interface
- `N`, 16: array dimension; number of lanes and number of beats per job.
- `W`, 8: element width in bits; must match the array.
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `a_col`  in  W*N: lane j is `a_col[W*j +: W]` = A[j][k] for beat k.
- `b_row`  in  W*N: lane j is `b_row[W*j +: W]` = B[k][j] for beat k.
- `in_valid`  in  1: the beat on `a_col`/`b_row` is valid.
- `in_ready`  out  1: the feeder accepts a beat this cycle.
- `in_a`  out  W*N: skewed A stream to the array.
- `in_b`  out  W*N: skewed B stream to the array.
- `en_in`  out  1: one-cycle job-complete pulse to the array.
- `busy`  out  1: high in FEED, FLUSH and DONE.

## Operation
- **FSM states:** IDLE, FEED, FLUSH, DONE. Reset state is IDLE.
- **Accept:** a beat is accepted when `in_valid && in_ready` at a rising edge.
- **IDLE:** `in_ready`=1. The first accept moves to FEED with beat count = 1. If N=1, it goes straight to FLUSH.
- **FEED:** `in_ready`=1.
  - Each accept increments the beat count. The Nth accept moves to FLUSH.
  - A cycle without an accept (a bubble) pushes an all-zero beat into the skew lanes. This is harmless because the products are zero. The beat count is not incremented.
- **FLUSH:**
  - `in_ready`=0.
  - Zeros are pushed into the lanes for exactly N cycles.
  - Then the FSM moves to DONE.
- **DONE:** `in_ready`=0, `en_in`=1, and all lanes are zero. Lasts one cycle, then returns to IDLE.
- **Skew lanes:** lane j is a delay line of depth j+1, registered, with the same depth for A and B. Data are passed through unchanged; there is no arithmetic and no width change.
- **Lane zero-padding:** outside a lane's active window the lane carries zero. This falls out of the zero pushes.
- `in_valid` is ignored when `in_ready`=0. `a_col`/`b_row` are don't-care when there is no accept.

## Timing
- **Reset values:** `in_a`=0, `in_b`=0, `en_in`=0, `busy`=0, and every delay register is 0.
- **`in_ready` after reset:** reset value is 0. It rises to 1 on the first `clk` edge after `reset_n` deasserts.
- **Latency:** a beat accepted at the edge ending cycle c appears on lane j of `in_a`/`in_b` during cycle c+1+j.
- **Job end:** the last accept is in cycle c. Lane N-1 shows that beat in cycle c+N. `en_in`=1 in cycle c+N+1. `in_ready` returns to 1 in cycle c+N+2.
- **Throughput:** a gap-free job of N beats occupies 2N+1 cycles from the first accept to the `en_in` pulse inclusive. Back-to-back jobs cannot overlap.
- **Outputs:** `in_a`, `in_b`, `en_in` and `in_ready` are all registered; there are no combinational input-to-output paths.
- **Reset mid-job:** all state is cleared immediately, with no partial `en_in` and no residual lane data. The next job starts from IDLE.
- **Counters:** beat and flush counters are `$clog2(N+1)` bits.

## Structure
- The shared package holds:
  - the state encoding (`IDLE`/`FEED`/`FLUSH`/`DONE` localparams);
  - the default `N`/`W`;
  - a lane-slice helper width constant.
- One natural sub-module, `skew_delay_line #(DEPTH, W)`, is instantiated once per lane for A and once per lane for B via a generate loop. It has async active-low reset to zero.
- The top level contains only the FSM, the counters and the generate loop.

## Test plan
- **Reset:** hold `reset_n`=0 with random `a_col`, then release.
  - Required: all outputs are 0 and `in_ready` rises one edge after release.
- **Gap-free job, N=4:** beats k=0..3 with `a_col` lanes all equal to k+1 and `b_row` = 1.
  - Required: `in_a` lane 3 shows 1,2,3,4 in cycles c0+4..c0+7.
  - Required: `en_in`=1 exactly in cycle c0+8, where c0 is the first accept cycle.
- **Bubble mid-feed, N=4:** `in_valid` drops for 2 cycles after beat 1.
  - Required: every lane carries two zeros between values 2 and 3.
  - Required: `en_in` is delayed by exactly 2 cycles.
- **Backpressure:** assert `in_valid` during FLUSH/DONE.
  - Required: no accept, `in_ready`=0, and lane contents are unchanged by the inputs.
- **Reset mid-FLUSH (N=16):** assert `reset_n`=0 at flush cycle 5.
  - Required: lanes clear to 0 with no `en_in` pulse.
  - Required: the next job's result matches the golden model.
- **End-to-end, N=16:** random 0–9 matrices are fed through this block into `top`.
  - Required: after `en_in`, `out` matches A×B truncated to 8 bits per the array's output convention.
